// File: rtl/egress_mq_fifo_sync_pkg.sv
// egress_mq_fifo_sync_pkg: shared defaults and helpers for the multi-queue egress FIFO
package egress_mq_fifo_sync_pkg;
  localparam int DATA_WIDTH_D   = 36;
  localparam int NR_OF_QUEUES_D = 4;
  localparam int Q_ADR_W_D      = 2;
  localparam int D_ADR_W_D      = 4;
  localparam int AFULL_LVL_D    = 12;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/egress_mq_fifo_sync_qctrl.sv
// egress_mq_qctrl: pointers, fill counter and status flags of one queue
module egress_mq_qctrl
  import egress_mq_fifo_sync_pkg::*;
#(
  parameter int D_ADR_W   = D_ADR_W_D,
  parameter int AFULL_LVL = AFULL_LVL_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wa_i,
  input  logic               ra_i,
  input  logic               flush_i,
  output logic [D_ADR_W-1:0] wptr_o,
  output logic [D_ADR_W-1:0] rptr_o,
  output logic               full_o,
  output logic               afull_o,
  output logic               empty_o
);
  localparam int DEPTH = 2**D_ADR_W;
  logic [D_ADR_W-1:0] r_wptr, r_rptr;
  logic [D_ADR_W:0]   r_cnt, w_cnt_nxt;
  logic               r_full, r_afull, r_empty;
  // next fill level; flush wins over any accept on this queue
  always_comb w_cnt_nxt = flush_i ? '0 : r_cnt + (D_ADR_W+1)'(wa_i) - (D_ADR_W+1)'(ra_i);
  // pointer/counter state with flags registered from the next count
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= flush_i ? '0 : r_wptr + D_ADR_W'(wa_i);
      r_rptr  <= flush_i ? '0 : r_rptr + D_ADR_W'(ra_i);
      r_cnt   <= w_cnt_nxt;
      r_full  <= w_cnt_nxt == (D_ADR_W+1)'(DEPTH);
      r_afull <= w_cnt_nxt >= (D_ADR_W+1)'(AFULL_LVL);
      r_empty <= w_cnt_nxt == '0;
    end
  end
  assign wptr_o  = r_wptr;
  assign rptr_o  = r_rptr;
  assign full_o  = r_full;
  assign afull_o = r_afull;
  assign empty_o = r_empty;
endmodule

// File: rtl/vfifo_dual_port_ram_sc_sw.sv
// vfifo_dual_port_ram_sc_sw: simple dual-port single-clock RAM with registered read
module vfifo_dual_port_ram_sc_sw #(
  parameter int DATA_WIDTH = 36,
  parameter int ADR_W      = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADR_W-1:0]      wadr,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [ADR_W-1:0]      radr,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADR_W];
  // write port and registered read port; contents are never cleared
  always_ff @(posedge clk) begin
    if (we) r_mem[wadr] <= d;
    q <= r_mem[radr];
  end
endmodule

// File: rtl/egress_mq_fifo_sync.sv
// egress_mq_fifo_sync: single-clock multi-queue egress FIFO over one shared RAM
module egress_mq_fifo_sync
  import egress_mq_fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_D,
  parameter int NR_OF_QUEUES = NR_OF_QUEUES_D,
  parameter int Q_ADR_W      = Q_ADR_W_D,
  parameter int D_ADR_W      = D_ADR_W_D,
  parameter int AFULL_LVL    = AFULL_LVL_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [Q_ADR_W-1:0]      wr_q,
  input  logic [DATA_WIDTH-1:0]   d,
  input  logic                    rd,
  input  logic [Q_ADR_W-1:0]      rd_q,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    q_valid,
  input  logic [NR_OF_QUEUES-1:0] flush,
  output logic [NR_OF_QUEUES-1:0] fifo_full,
  output logic [NR_OF_QUEUES-1:0] fifo_afull,
  output logic [NR_OF_QUEUES-1:0] fifo_empty,
  output logic                    wr_err,
  output logic                    rd_err
);
  localparam int NQ_ALL    = 2**Q_ADR_W;
  localparam int RAM_ADR_W = Q_ADR_W + D_ADR_W;
  if (Q_ADR_W < clog2(NR_OF_QUEUES)) begin : g_bad_q_adr_w
    $error("Q_ADR_W too small for NR_OF_QUEUES");
  end
  // status padded to the full index range so out-of-range queues read as idle
  logic [NQ_ALL-1:0]     w_full_x, w_afull_x, w_empty_x, w_flush_x;
  logic [D_ADR_W-1:0]    w_wptr [NQ_ALL];
  logic [D_ADR_W-1:0]    w_rptr [NQ_ALL];
  logic                  w_wa, w_ra;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic [RAM_ADR_W-1:0]  r_radr;
  logic                  r_rv1, r_rv2, r_q_valid, r_wr_err, r_rd_err;
  logic [DATA_WIDTH-1:0] r_q;
  assign w_wa = wr & (int'(wr_q) < NR_OF_QUEUES) & !w_full_x[wr_q] & !w_flush_x[wr_q];
  assign w_ra = rd & (int'(rd_q) < NR_OF_QUEUES) & !w_empty_x[rd_q] & !w_flush_x[rd_q];
  for (genvar i = 0; i < NQ_ALL; i++) begin : g_q
    if (i < NR_OF_QUEUES) begin : g_on
      egress_mq_qctrl #(.D_ADR_W(D_ADR_W), .AFULL_LVL(AFULL_LVL)) u_qctrl (
        .clk     (clk),
        .rst     (rst),
        .wa_i    (w_wa & (wr_q == Q_ADR_W'(i))),
        .ra_i    (w_ra & (rd_q == Q_ADR_W'(i))),
        .flush_i (flush[i]),
        .wptr_o  (w_wptr[i]),
        .rptr_o  (w_rptr[i]),
        .full_o  (w_full_x[i]),
        .afull_o (w_afull_x[i]),
        .empty_o (w_empty_x[i])
      );
      assign w_flush_x[i] = flush[i];
    end else begin : g_off
      assign w_wptr[i]    = '0;
      assign w_rptr[i]    = '0;
      assign w_full_x[i]  = 1'b0;
      assign w_afull_x[i] = 1'b0;
      assign w_empty_x[i] = 1'b1;
      assign w_flush_x[i] = 1'b0;
    end
  end
  vfifo_dual_port_ram_sc_sw #(.DATA_WIDTH(DATA_WIDTH), .ADR_W(RAM_ADR_W)) u_ram (
    .clk  (clk),
    .we   (w_wa),
    .wadr ({wr_q, w_wptr[wr_q]}),
    .d    (d),
    .radr (r_radr),
    .q    (w_ram_q)
  );
  // read pipeline: address latched at accept, RAM output next, q one cycle later
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_radr    <= '0;
      r_rv1     <= 1'b0;
      r_rv2     <= 1'b0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_wr_err  <= 1'b0;
      r_rd_err  <= 1'b0;
    end else begin
      r_radr    <= {rd_q, w_rptr[rd_q]};
      r_rv1     <= w_ra;
      r_rv2     <= r_rv1;
      r_q       <= r_rv2 ? w_ram_q : r_q;
      r_q_valid <= r_rv2;
      r_wr_err  <= wr & !w_wa;
      r_rd_err  <= rd & !w_ra;
    end
  end
  assign q          = r_q;
  assign q_valid    = r_q_valid;
  assign wr_err     = r_wr_err;
  assign rd_err     = r_rd_err;
  assign fifo_full  = w_full_x[NR_OF_QUEUES-1:0];
  assign fifo_afull = w_afull_x[NR_OF_QUEUES-1:0];
  assign fifo_empty = w_empty_x[NR_OF_QUEUES-1:0];
endmodule

// File: tb/tb_egress_mq_fifo_sync.sv
// tb_egress_mq_fifo_sync: directed vector bench for the multi-queue egress FIFO
module tb_egress_mq_fifo_sync;
  logic        clk, rst, wr, rd, q_valid, wr_err, rd_err;
  logic [1:0]  wr_q, rd_q;
  logic [35:0] d, q;
  logic [3:0]  flush, fifo_full, fifo_afull, fifo_empty;
  int          total, bad;
  logic        pv0, pv1;
  logic [35:0] pd0, pd1, last_q;

  typedef struct {
    logic wr; logic [1:0] wq; logic [35:0] wd;
    logic rd; logic [1:0] rq; logic [3:0] fl;
    logic [3:0] e_empty; logic e_werr; logic e_rerr; logic e_qv; logic [35:0] e_q;
  } vec_t;
  vec_t tv [17];

  egress_mq_fifo_sync dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_q(wr_q), .d(d), .rd(rd), .rd_q(rd_q),
    .q(q), .q_valid(q_valid), .flush(flush), .fifo_full(fifo_full),
    .fifo_afull(fifo_afull), .fifo_empty(fifo_empty), .wr_err(wr_err), .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic w, input logic [1:0] wq, input logic [35:0] wd,
                              input logic r, input logic [1:0] rq, input logic [3:0] e,
                              input logic rerr, input logic qv, input logic [35:0] eq);
    vec_t v;
    v.wr = w; v.wq = wq; v.wd = wd; v.rd = r; v.rq = rq; v.fl = 4'b0;
    v.e_empty = e; v.e_werr = 1'b0; v.e_rerr = rerr; v.e_qv = qv; v.e_q = eq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] wq, input logic [35:0] wd,
                       input logic r, input logic [1:0] rq, input logic [3:0] fl);
    wr = w; wr_q = wq; d = wd; rd = r; rd_q = rq; flush = fl;
    @(posedge clk);
    #1;
  endtask

  // one cycle plus checks of the expected read pipeline and error pulses
  task automatic cyc(input logic w, input logic [1:0] wq, input logic [35:0] wd,
                     input logic r, input logic [1:0] rq, input logic [3:0] fl,
                     input logic xra, input logic [35:0] xd, input logic xwe, input logic xre);
    drive(w, wq, wd, r, rq, fl);
    chk("q_valid", q_valid, pv1);
    if (pv1) begin
      chk("q_data", q, pd1);
      last_q = pd1;
    end else chk("q_hold", q, last_q);
    pv1 = pv0; pd1 = pd0; pv0 = xra; pd0 = xd;
    chk("wr_err", wr_err, xwe);
    chk("rd_err", rd_err, xre);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_state();
    chk("rst_empty", fifo_empty, 4'hF);
    chk("rst_full", fifo_full, 4'h0);
    chk("rst_afull", fifo_afull, 4'h0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_rd_err", rd_err, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    pv0 = 0; pv1 = 0; pd0 = 0; pd1 = 0; last_q = 0;
    tv[0]  = mk(0, 0, 0,         0, 0, 4'b1111, 0, 0, 36'h0);
    tv[1]  = mk(0, 0, 0,         1, 0, 4'b1111, 1, 0, 36'h0);
    tv[2]  = mk(0, 0, 0,         0, 0, 4'b1111, 0, 0, 36'h0);
    tv[3]  = mk(0, 0, 0,         0, 0, 4'b1111, 0, 0, 36'h0);
    tv[4]  = mk(1, 0, 36'h0A0,   0, 0, 4'b1110, 0, 0, 36'h0);
    tv[5]  = mk(1, 1, 36'h0B0,   0, 0, 4'b1100, 0, 0, 36'h0);
    tv[6]  = mk(1, 3, 36'h0C0,   0, 0, 4'b0100, 0, 0, 36'h0);
    tv[7]  = mk(1, 0, 36'h0A1,   0, 0, 4'b0100, 0, 0, 36'h0);
    tv[8]  = mk(1, 1, 36'h0B1,   1, 0, 4'b0100, 0, 0, 36'h0);
    tv[9]  = mk(1, 3, 36'h0C1,   1, 1, 4'b0100, 0, 0, 36'h0);
    tv[10] = mk(0, 0, 0,         1, 3, 4'b0100, 0, 1, 36'h0A0);
    tv[11] = mk(0, 0, 0,         1, 0, 4'b0101, 0, 1, 36'h0B0);
    tv[12] = mk(0, 0, 0,         1, 1, 4'b0111, 0, 1, 36'h0C0);
    tv[13] = mk(0, 0, 0,         1, 3, 4'b1111, 0, 1, 36'h0A1);
    tv[14] = mk(0, 0, 0,         1, 0, 4'b1111, 1, 1, 36'h0B1);
    tv[15] = mk(0, 0, 0,         0, 0, 4'b1111, 0, 1, 36'h0C1);
    tv[16] = mk(0, 0, 0,         0, 0, 4'b1111, 0, 0, 36'h0C1);

    wr = 0; wr_q = 0; d = 0; rd = 0; rd_q = 0; flush = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b1;

    // idle, rejected read and interleaved queues from the vector table
    for (int i = 0; i < 17; i++) begin
      drive(tv[i].wr, tv[i].wq, tv[i].wd, tv[i].rd, tv[i].rq, tv[i].fl);
      chk($sformatf("v%0d_empty", i), fifo_empty, tv[i].e_empty);
      chk($sformatf("v%0d_full_afull", i), {fifo_full, fifo_afull}, 8'h00);
      chk($sformatf("v%0d_wr_err", i), wr_err, tv[i].e_werr);
      chk($sformatf("v%0d_rd_err", i), rd_err, tv[i].e_rerr);
      chk($sformatf("v%0d_q_valid", i), q_valid, tv[i].e_qv);
      chk($sformatf("v%0d_q", i), q, tv[i].e_q);
    end
    last_q = 36'h0C1;

    // fill q2 to full, overflow, then drain in order
    for (int i = 0; i < 16; i++) begin
      cyc(1, 2, 36'(i), 0, 0, 0, 0, 0, 0, 0);
      chk("q2_afull", fifo_afull[2], i >= 11);
      chk("q2_full", fifo_full[2], i == 15);
      chk("q2_empty", fifo_empty[2], 0);
    end
    cyc(1, 2, 36'h10, 0, 0, 0, 0, 0, 1, 0);
    chk("q2_full_ovf", fifo_full[2], 1);
    for (int k = 0; k < 18; k++) begin
      cyc(0, 0, 0, k < 16, 2, 0, k < 16, 36'(k), 0, 0);
      if (k == 0) chk("q2_full_drop", fifo_full[2], 0);
      if (k == 3) chk("q2_afull_12", fifo_afull[2], 1);
      if (k == 4) chk("q2_afull_11", fifo_afull[2], 0);
      if (k == 15) chk("q2_empty_end", fifo_empty[2], 1);
    end

    // full q1 with simultaneous write and read: write rejected
    for (int i = 0; i < 16; i++) cyc(1, 1, 36'('h100 + i), 0, 0, 0, 0, 0, 0, 0);
    chk("q1_full", fifo_full[1], 1);
    cyc(1, 1, 36'h1FF, 1, 1, 0, 1, 36'h100, 1, 0);
    chk("q1_full_15", fifo_full[1], 0);
    chk("q1_afull_15", fifo_afull[1], 1);
    cyc(1, 1, 36'h1AA, 0, 0, 0, 0, 0, 0, 0);
    chk("q1_full_again", fifo_full[1], 1);
    for (int k = 0; k < 18; k++)
      cyc(0, 0, 0, k < 16, 1, 0, k < 16, k < 15 ? 36'('h101 + k) : 36'h1AA, 0, 0);
    chk("q1_empty_end", fifo_empty[1], 1);

    // flush q3 behind an in-flight read
    for (int i = 0; i < 5; i++) cyc(1, 3, 36'('h300 + i), 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 0, 1, 36'h300, 0, 0);
    cyc(1, 3, 36'h3FF, 1, 3, 4'b1000, 0, 0, 1, 1);
    chk("q3_empty_flush", fifo_empty[3], 1);
    chk("q3_afull_flush", fifo_afull[3], 0);
    cyc(1, 3, 36'h3AB, 0, 0, 0, 0, 0, 0, 0);
    chk("q3_empty_wr", fifo_empty[3], 0);
    cyc(0, 0, 0, 1, 3, 0, 1, 36'h3AB, 0, 0);
    chk("q3_empty_rd", fifo_empty[3], 1);
    idle();
    idle();

    // wrap q0 at steady occupancy 3, then reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1, 0, 36'('h600 + i), 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 36'('h603 + i), 1, 0, 0, 1, 36'('h600 + i), 0, 0);
      chk("q0_occ_empty", fifo_empty[0], 0);
    end
    rst = 1'b0;
    drive(1, 0, 36'h6FF, 1, 0, 0);
    chk_reset_state();
    rst = 1'b1;
    pv0 = 0; pv1 = 0; last_q = 0;
    idle();
    idle();
    chk("post_rst_empty", fifo_empty, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
